// File: rtl/bus_arbiter2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter2_pkg
//  Description : Shared definitions for the two-requester bus arbiter: the
//                2-bit arbiter state encoding and the default ownership limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter2_pkg;

    // Default maximum number of consecutive cycles a single requester may own the bus
    localparam int c_MAX_HOLD_DEFAULT = 8;

    // Arbiter state encoding
    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage : bus_arbiter2_pkg
`default_nettype wire

// File: rtl/bus_arbiter2_mux.sv
`default_nettype none
// ============================================================================
//  Module      : MainMux
//  Description : W-bit 2:1 multiplexer. Out = sel ? One : Zero.
//  Ports       : One, Zero - data inputs (W bits)
//                sel       - select, 1 picks One
//                Out       - selected data (W bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module MainMux #(
    parameter int W = 32
) (
    input  logic [W-1:0] One,
    input  logic [W-1:0] Zero,
    input  logic         sel,
    output logic [W-1:0] Out
);

    assign Out = sel ? One : Zero;

endmodule : MainMux
`default_nettype wire

// File: rtl/bus_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter2
//  Description : Two-requester shared-bus arbiter. Grants are one-hot from a
//                three-state FSM (IDLE/OWN0/OWN1), ties resolve to the
//                requester that did not own the bus last, and ownership is
//                capped at MAX_HOLD consecutive cycles. The owner's data is
//                registered onto bus_out one cycle after the grant.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                req0/req1         - bus requests
//                done0/done1       - end of transaction from the owner
//                data0/data1       - requester data (W bits)
//                gnt0/gnt1         - grants (one-hot or both zero)
//                sel               - data select (1 = data1)
//                bus_out/bus_valid - registered bus data and its qualifier
//                busy              - a requester currently owns the bus
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter2
    import bus_arbiter2_pkg::*;
#(
    parameter int W        = 32,
    parameter int MAX_HOLD = c_MAX_HOLD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic         done0,
    input  logic         done1,
    input  logic [W-1:0] data0,
    input  logic [W-1:0] data1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         sel,
    output logic [W-1:0] bus_out,
    output logic         bus_valid,
    output logic         busy
);

    localparam int                c_HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_last_owner;
    logic [W-1:0]        r_bus_out;
    logic                r_bus_valid;
    logic                w_hold_last;
    logic                w_enter;
    logic [W-1:0]        w_mux_out;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and Moore outputs
    // ------------------------------------------------------------------
    assign w_hold_last = (r_hold_cnt == c_HOLD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        sel         = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the requester that did not own the bus last wins
                if (req0 && req1) begin
                    w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    w_state_nxt = ST_OWN0;
                end else if (req1) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                gnt0 = 1'b1;
                busy = 1'b1;
                // All release causes collapse into one transition
                if (done0 || !req0 || w_hold_last) begin
                    w_state_nxt = req1 ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                gnt1 = 1'b1;
                sel  = 1'b1;
                busy = 1'b1;
                if (done1 || !req1 || w_hold_last) begin
                    w_state_nxt = req0 ? ST_OWN0 : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Entry into an ownership state, from IDLE or a direct handover
    assign w_enter = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);

    // ------------------------------------------------------------------
    // Hold counter and last-owner tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt   <= '0;
            r_last_owner <= 1'b1;
        end else begin
            if (w_enter) begin
                r_last_owner <= (w_state_nxt == ST_OWN1);
            end
            // Staying in an OWN state implies the count is below the limit,
            // so the increment never wraps.
            if (w_enter || (w_state_nxt == ST_IDLE)) begin
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data path
    // ------------------------------------------------------------------
    MainMux #(
        .W    (W)
    ) u_mux (
        .One  (data1),
        .Zero (data0),
        .sel  (sel),
        .Out  (w_mux_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
        end else begin
            r_bus_valid <= busy;
            if (busy) begin
                r_bus_out <= w_mux_out;
            end
        end
    end

    assign bus_out   = r_bus_out;
    assign bus_valid = r_bus_valid;

endmodule : bus_arbiter2
`default_nettype wire

// File: tb/tb_bus_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter2
//  Description : Directed self-checking bench for bus_arbiter2 (W=32,
//                MAX_HOLD=8). Inputs change 1 ns after each rising edge and
//                outputs are checked at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter2;

    localparam int W        = 32;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0;
    logic         req1;
    logic         done0;
    logic         done1;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic         gnt0;
    logic         gnt1;
    logic         sel;
    logic [W-1:0] bus_out;
    logic         bus_valid;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter2 #(
        .W         (W),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .done0     (done0),
        .done1     (done1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant-side outputs: only the expected owner is given, sel/busy follow from it
    task automatic chk_own(input string tag, input logic eg0, input logic eg1);
        chk({tag, ".gnt0"}, W'(gnt0), W'(eg0));
        chk({tag, ".gnt1"}, W'(gnt1), W'(eg1));
        chk({tag, ".sel"},  W'(sel),  W'(eg1));
        chk({tag, ".busy"}, W'(busy), W'(eg0 | eg1));
    endtask

    task automatic chk_bus(input string tag, input logic ev, input logic [W-1:0] ed);
        chk({tag, ".bus_valid"}, W'(bus_valid), W'(ev));
        chk({tag, ".bus_out"},   bus_out,       ed);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        done0 = 1'b0;
        done1 = 1'b0;
        data0 = 32'hA5A5_0001;
        data1 = 32'h0000_0000;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk_own("reset", 1'b0, 1'b0);
        chk_bus("reset", 1'b0, 32'h0);

        // ---------------- single owner, done0 in cycle 4 ----------------
        rst  = 1'b0;
        req0 = 1'b1;
        tick();                                   // cycle 1
        chk_own("t1.c1", 1'b1, 1'b0);
        chk("t1.c1.bus_valid", W'(bus_valid), W'(1'b0));
        tick();                                   // cycle 2
        chk_own("t1.c2", 1'b1, 1'b0);
        chk_bus("t1.c2", 1'b1, 32'hA5A5_0001);
        tick();                                   // cycle 3
        chk_own("t1.c3", 1'b1, 1'b0);
        tick();                                   // cycle 4
        chk_own("t1.c4", 1'b1, 1'b0);
        done0 = 1'b1;
        tick();                                   // cycle 5
        chk_own("t1.c5", 1'b0, 1'b0);
        chk_bus("t1.c5", 1'b1, 32'hA5A5_0001);
        done0 = 1'b0;
        req0  = 1'b0;
        data0 = 32'h1111_2222;
        tick();                                   // cycle 6: bus_out holds
        chk_own("t1.c6", 1'b0, 1'b0);
        chk_bus("t1.c6", 1'b0, 32'hA5A5_0001);

        // ---------------- tie, handover, data, timeout ----------------
        rst = 1'b1;
        tick();
        chk_bus("t2.rst", 1'b0, 32'h0);
        rst   = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 32'hDEAD_BEEF;
        data1 = 32'h1234_5678;
        tick();                                   // c1: tie -> requester 0
        chk_own("t2.c1", 1'b1, 1'b0);
        tick();                                   // c2
        chk_own("t2.c2", 1'b1, 1'b0);
        chk_bus("t2.c2", 1'b1, 32'hDEAD_BEEF);
        done0 = 1'b1;
        tick();                                   // c3: direct handover
        chk_own("t2.c3", 1'b0, 1'b1);
        chk_bus("t2.c3", 1'b1, 32'hDEAD_BEEF);
        done0 = 1'b0;
        req0  = 1'b0;
        tick();                                   // c4
        chk_own("t2.c4", 1'b0, 1'b1);
        chk_bus("t2.c4", 1'b1, 32'h1234_5678);
        for (int i = 5; i <= 10; i++) begin       // gnt1 owned c3..c10
            tick();
            chk_own($sformatf("t2.c%0d", i), 1'b0, 1'b1);
        end
        tick();                                   // c11: forced release
        chk_own("t2.c11", 1'b0, 1'b0);
        chk_bus("t2.c11", 1'b1, 32'h1234_5678);
        tick();                                   // c12: re-grant
        chk_own("t2.c12", 1'b0, 1'b1);
        chk("t2.c12.bus_valid", W'(bus_valid), W'(1'b0));

        // ---------------- reset during OWN1 ----------------
        rst  = 1'b1;
        req0 = 1'b1;
        done1 = 1'b1;
        tick();
        chk_own("t3.rst", 1'b0, 1'b0);
        chk_bus("t3.rst", 1'b0, 32'h0);
        rst   = 1'b0;
        done1 = 1'b0;
        tick();                                   // c1: tie -> requester 0
        chk_own("t3.c1", 1'b1, 1'b0);

        // ---------------- done1 while gnt0: no effect, full hold ----------------
        req1  = 1'b0;
        done1 = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk_own($sformatf("t4.c%0d", i), 1'b1, 1'b0);
            done1 = (i % 2 == 0);
        end
        done1 = 1'b0;
        tick();                                   // c9: timeout -> IDLE
        chk_own("t4.c9", 1'b0, 1'b0);
        req1 = 1'b1;                              // tie with last owner 0
        tick();                                   // c10
        chk_own("t4.c10", 1'b0, 1'b1);
        chk_bus("t4.c10", 1'b0, 32'hDEAD_BEEF);

        // ---------------- release by req drop, done at timeout ----------------
        req1 = 1'b0;
        tick();                                   // OWN1 -> OWN0 directly
        chk_own("t5.c1", 1'b1, 1'b0);
        chk_bus("t5.c1", 1'b1, 32'h1234_5678);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk_own($sformatf("t5.c%0d", i), 1'b1, 1'b0);
        end
        done0 = 1'b1;                             // done together with timeout
        tick();
        chk_own("t5.rel", 1'b0, 1'b0);
        done0 = 1'b0;
        req0  = 1'b0;
        tick();
        chk_own("t5.idle", 1'b0, 1'b0);
        chk_bus("t5.idle", 1'b0, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bus_arbiter2
`default_nettype wire

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 Parameter W, default 32: width of each requester data bus and of bus_out.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive cycles one requester may own the bus; legal range 2..256.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0, req1  input  1 each  bus request from requester 0 / requester 1.
REQ-006 done0, done1  input  1 each  owner signals end of transaction; ignored when that requester is not granted.
REQ-007 data0, data1  input  W each  requester data.
REQ-008 gnt0, gnt1  output  1 each  grant; one-hot or both zero, never both high.
REQ-009 sel  output  1  mux select: 1 selects data1, 0 selects data0.
REQ-010 bus_out  output  W  registered shared-bus data.
REQ-011 bus_valid  output  1  bus_out carries owner data this cycle.
REQ-012 busy  output  1  high while any requester owns the bus.

Function
REQ-013 The FSM SHALL have states IDLE, OWN0 and OWN1; gnt0=(state==OWN0), gnt1=(state==OWN1), busy=(state!=IDLE), sel=(state==OWN1).
REQ-014 In IDLE: req0 only -> OWN0; req1 only -> OWN1; neither -> IDLE.
REQ-015 In IDLE with req0 and req1 both high, the requester not recorded in last_owner SHALL win.
REQ-016 last_owner SHALL update to the owner index on every entry into OWN0 or OWN1.
REQ-017 Request-to-grant latency SHALL be exactly 1 cycle: a request sampled high in IDLE yields a grant on the next cycle.
REQ-018 hold_cnt, of width clog2(MAX_HOLD), SHALL clear on every entry into an OWN state and increment on each owned cycle.
REQ-019 In OWNx, release SHALL occur when doneX=1, reqX=0, or hold_cnt==MAX_HOLD-1, whichever comes first.
REQ-020 On release, if the other requester's req is high, the FSM SHALL go directly to the other OWN state with no IDLE bubble; otherwise it SHALL go to IDLE.
REQ-021 A forced release at MAX_HOLD with the other requester idle SHALL go to IDLE; the same requester may be re-granted from IDLE on the following cycle.
REQ-022 Each cycle, bus_out <= (sel ? data1 : data0) when busy and bus_valid <= busy; when not busy, bus_out SHALL hold its value and bus_valid <= 0.
REQ-023 bus_out and bus_valid SHALL therefore lag the grant by exactly one cycle.
REQ-024 doneX asserted together with release by timeout SHALL produce a single release, not a double transition.

Reset
REQ-025 With rst high at a clock edge: state=IDLE, gnt0=gnt1=0, sel=0, busy=0, bus_valid=0, bus_out=0, hold_cnt=0, last_owner=1 (requester 0 wins the first tie).
REQ-026 Reset asserted mid-transaction SHALL drop the grant at that edge, with no completion cycle.
REQ-027 rst SHALL take priority over every request and done input.

Structure
REQ-028 State encoding (2 bits) and default MAX_HOLD SHALL live in the shared processor package.
REQ-029 The data select SHALL reuse the team's W-parameterized 2:1 mux (MainMux) as the single sub-module, driven by sel, with One=data1 and Zero=data0.

Verification
REQ-030 Reset then req0=1 held and done0 pulsed in cycle 4 -> gnt0 in cycles 1..4, bus_valid in cycles 2..5, IDLE in cycle 5.
REQ-031 After reset, req0=req1=1 together -> gnt0 first; after done0, gnt1 on the very next cycle with sel=1 and no IDLE cycle.
REQ-032 MAX_HOLD=8, req1 held high with no done1 -> gnt1 exactly 8 cycles, then IDLE for 1 cycle, then re-grant.
REQ-033 data0=32'hDEADBEEF, data1=32'h12345678, handover 0->1 -> bus_out shows DEADBEEF, then 12345678 one cycle after gnt1 rises.
REQ-034 rst pulsed during OWN1 -> gnt1=0, bus_valid=0 and bus_out=0 at the following edge; the next tie goes to requester 0.
REQ-035 done1 pulsed while gnt0 is active -> no state change; gnt0 and hold_cnt are unaffected.
